// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcode map, FSM state encoding and shared helpers for alu_seq.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b0110;
  localparam logic [3:0] OP_SHL = 4'b0111;
  localparam logic [3:0] OP_SHR = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001;
  localparam logic [3:0] OP_DIV = 4'b1010;
  localparam logic [3:0] OP_MOD = 4'b1011;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  typedef struct packed {
    logic div_by_zero;
    logic illegal_op;
  } alu_flags_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_MOD);
  endfunction

  // Iterative ops enter their loop state; everything else finishes next cycle.
  function automatic logic [1:0] first_state(input logic [3:0] op);
    case (op)
      OP_MUL:         return MUL;
      OP_DIV, OP_MOD: return DIV;
      default:        return DONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_if
// Brief    : start/busy/done request bus between issue logic and alu_seq.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
  parameter int WIDTH = 16
) ();

  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [3:0]           alu_op;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic                 zero;
  logic                 div_by_zero;
  logic                 illegal_op;

  modport master (
    output start, a, b, alu_op,
    input  busy, done, result, zero, div_by_zero, illegal_op
  );

  modport slave (
    input  start, a, b, alu_op,
    output busy, done, result, zero, div_by_zero, illegal_op
  );

endinterface
`default_nettype wire

// File: rtl/alu_seq_divstep.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_divstep
// Brief    : One combinational restoring-division step (compare, subtract).
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_divstep #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH-1:0] w_diff;

  // When the subtract is taken the difference is below divisor, so WIDTH bits suffice.
  assign q_bit   = (rem_in >= {1'b0, divisor});
  assign w_diff  = rem_in[WIDTH-1:0] - divisor;
  assign rem_out = q_bit ? w_diff : rem_in[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Registered ALU; single-cycle logic ops, iterative MUL/DIV/MOD.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);

  localparam int RW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] c_shl_lim = WIDTH'(2 * WIDTH);
  localparam logic [WIDTH-1:0] c_shr_lim = WIDTH'(WIDTH);
  localparam logic [CNT_W-1:0] c_last    = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [RW-1:0]    r_mcand;
  logic [RW-1:0]    r_acc;
  logic [WIDTH-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic [RW-1:0]    r_result;
  logic             r_zero;
  alu_flags_t       r_flags;
  logic             r_busy;
  logic             r_done;

  logic [1:0]       w_state_nxt;
  logic             w_load;
  logic [RW-1:0]    w_result_nxt;
  alu_flags_t       w_flags_nxt;
  logic [RW-1:0]    w_a_ext;
  logic [RW-1:0]    w_b_ext;
  logic [RW-1:0]    w_single;
  logic [RW-1:0]    w_mul_next;
  logic [WIDTH-1:0] w_rem_next;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_quo_final;
  logic [RW-1:0]    w_div_result;

  assign w_a_ext = {{WIDTH{1'b0}}, bus.a};
  assign w_b_ext = {{WIDTH{1'b0}}, bus.b};

  always_comb begin
    w_single = '0;
    case (bus.alu_op)
      OP_ADD:  w_single = w_a_ext + w_b_ext;
      OP_SUB:  w_single = w_a_ext - w_b_ext;
      OP_AND:  w_single = w_a_ext & w_b_ext;
      OP_OR:   w_single = w_a_ext | w_b_ext;
      OP_XOR:  w_single = w_a_ext ^ w_b_ext;
      OP_NOT:  w_single = {{WIDTH{1'b0}}, ~bus.a};
      OP_SHL:  w_single = (bus.b >= c_shl_lim) ? '0 : (w_a_ext << bus.b);
      OP_SHR:  w_single = (bus.b >= c_shr_lim) ? '0 : (w_a_ext >> bus.b);
      default: w_single = '0;
    endcase
  end

  // Shift-add: r_b is consumed LSB first while the multiplicand walks left.
  assign w_mul_next = r_acc + (r_b[0] ? r_mcand : '0);

  // r_a doubles as dividend shifter and quotient collector.
  alu_seq_divstep #(
    .WIDTH (WIDTH)
  ) u_divstep (
    .rem_in  ({r_rem, r_a[WIDTH-1]}),
    .divisor (r_b),
    .rem_out (w_rem_next),
    .q_bit   (w_q_bit)
  );

  assign w_quo_final  = {r_a[WIDTH-2:0], w_q_bit};
  assign w_div_result = (r_op == OP_MOD) ? {{WIDTH{1'b0}}, w_rem_next}
                                         : {{WIDTH{1'b0}}, w_quo_final};

  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_result_nxt = '0;
    w_flags_nxt  = '0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = first_state(bus.alu_op);
          if (first_state(bus.alu_op) == DONE) begin
            w_load                 = 1'b1;
            w_result_nxt           = w_single;
            w_flags_nxt.illegal_op = !op_is_legal(bus.alu_op);
          end
        end
      end
      MUL: begin
        if (r_cnt == c_last) begin
          w_state_nxt  = DONE;
          w_load       = 1'b1;
          w_result_nxt = w_mul_next;
        end
      end
      DIV: begin
        // A zero divisor falls out of the algorithm as all-ones / dividend.
        if (r_cnt == c_last) begin
          w_state_nxt             = DONE;
          w_load                  = 1'b1;
          w_result_nxt            = w_div_result;
          w_flags_nxt.div_by_zero = (r_b == '0);
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_flags  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (w_state_nxt == DONE);
      if (w_load) begin
        r_result <= w_result_nxt;
        r_zero   <= (w_result_nxt == '0);
        r_flags  <= w_flags_nxt;
      end
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_op    <= bus.alu_op;
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_mcand <= w_a_ext;
            r_acc   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
          end
        end
        MUL: begin
          r_acc   <= w_mul_next;
          r_mcand <= r_mcand << 1;
          r_b     <= r_b >> 1;
          r_cnt   <= r_cnt + CNT_W'(1);
        end
        DIV: begin
          r_rem <= w_rem_next;
          r_a   <= w_quo_final;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.result      = r_result;
  assign bus.zero        = r_zero;
  assign bus.div_by_zero = r_flags.div_by_zero;
  assign bus.illegal_op  = r_flags.illegal_op;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Brief    : Self-checking bench: vector table, random ops vs model, corners.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  localparam int W = 16;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] res;
    logic        z;
    logic        dbz;
    logic        ill;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        dbz;
    logic        ill;
    int          lat;
  } ref_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                              input logic [31:0] res, input logic dbz, input logic ill, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res;
    v.z = (res == 32'h0); v.dbz = dbz; v.ill = ill; v.lat = lat;
    return v;
  endfunction

  // Reference model straight from the opcode table, using native arithmetic.
  function automatic ref_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    ref_t r;
    logic [31:0] ae;
    logic [31:0] be;
    ae = {16'h0, a};
    be = {16'h0, b};
    r.dbz = 1'b0; r.ill = 1'b0; r.lat = 1; r.res = 32'h0;
    case (op)
      4'd1:  r.res = ae + be;
      4'd2:  r.res = ae - be;
      4'd3:  r.res = ae & be;
      4'd4:  r.res = ae | be;
      4'd5:  r.res = ae ^ be;
      4'd6:  r.res = {16'h0, ~a};
      4'd7:  r.res = (b >= 16'd32) ? 32'h0 : (ae << b);
      4'd8:  r.res = (b >= 16'd16) ? 32'h0 : (ae >> b);
      4'd9:  begin r.res = ae * be; r.lat = W + 1; end
      4'd10: begin r.res = (b == 0) ? 32'h0000_FFFF : ae / be; r.dbz = (b == 0); r.lat = W + 1; end
      4'd11: begin r.res = (b == 0) ? ae : ae % be; r.dbz = (b == 0); r.lat = W + 1; end
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

  // Issues one request and waits (bounded) for done; inputs are scrambled while busy.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic [31:0] res, output logic z, output logic dbz,
                        output logic ill, output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.alu_op = op; bus.a = a; bus.b = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.alu_op = 4'($urandom); bus.a = 16'($urandom); bus.b = 16'($urandom);
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.done) lat = -1;
    res = bus.result; z = bus.zero; dbz = bus.div_by_zero; ill = bus.illegal_op;
  endtask

  task automatic check_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [31:0] eres, input logic ez,
                          input logic edbz, input logic eill, input int elat);
    logic [31:0] res;
    logic z, dbz, ill;
    int lat;
    run_op(op, a, b, res, z, dbz, ill, lat);
    if (res !== eres || z !== ez || dbz !== edbz || ill !== eill || lat != elat)
      $display("  op=%h a=%h b=%h", op, a, b);
    check({tag, " result"}, 64'(res), 64'(eres));
    check({tag, " zero"}, 64'(z), 64'(ez));
    check({tag, " div_by_zero"}, 64'(dbz), 64'(edbz));
    check({tag, " illegal_op"}, 64'(ill), 64'(eill));
    check({tag, " latency"}, 64'(lat), 64'(elat));
  endtask

  initial begin
    logic [3:0]  op;
    logic [15:0] ra;
    logic [15:0] rb;
    ref_t        m;

    bus.start = 1'b0; bus.alu_op = 4'h0; bus.a = 16'h0; bus.b = 16'h0;

    tbl.push_back(mk(4'b0001, 16'hFFFF, 16'h0001, 32'h0001_0000, 0, 0, 1));
    tbl.push_back(mk(4'b1001, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 0, 0, 17));
    tbl.push_back(mk(4'b1010, 16'd100,  16'd7,    32'd14,        0, 0, 17));
    tbl.push_back(mk(4'b1011, 16'd100,  16'd7,    32'd2,         0, 0, 17));
    tbl.push_back(mk(4'b1010, 16'd5,    16'd0,    32'h0000_FFFF, 1, 0, 17));
    tbl.push_back(mk(4'b0111, 16'd1,    16'd31,   32'h8000_0000, 0, 0, 1));
    tbl.push_back(mk(4'b1000, 16'h8000, 16'd16,   32'h0,         0, 0, 1));
    tbl.push_back(mk(4'b0110, 16'h00FF, 16'h0,    32'h0000_FF00, 0, 0, 1));
    tbl.push_back(mk(4'b1111, 16'h1234, 16'h5678, 32'h0,         0, 1, 1));
    tbl.push_back(mk(4'b0001, 16'd2,    16'd3,    32'd5,         0, 0, 1));
    tbl.push_back(mk(4'b0010, 16'd3,    16'd5,    32'hFFFF_FFFE, 0, 0, 1));
    tbl.push_back(mk(4'b1011, 16'd5,    16'd0,    32'd5,         1, 0, 17));
    tbl.push_back(mk(4'b0111, 16'd1,    16'd32,   32'h0,         0, 0, 1));
    tbl.push_back(mk(4'b0011, 16'hF0F0, 16'hFF00, 32'h0000_F000, 0, 0, 1));
    tbl.push_back(mk(4'b0100, 16'hF0F0, 16'hFF00, 32'h0000_FFF0, 0, 0, 1));
    tbl.push_back(mk(4'b0101, 16'hF0F0, 16'hFF00, 32'h0000_0FF0, 0, 0, 1));
    tbl.push_back(mk(4'b0000, 16'h0001, 16'h0001, 32'h0,         0, 1, 1));
    tbl.push_back(mk(4'b1000, 16'h8000, 16'd15,   32'h1,         0, 0, 1));
    tbl.push_back(mk(4'b1010, 16'hFFFF, 16'd1,    32'h0000_FFFF, 0, 0, 17));
    tbl.push_back(mk(4'b1001, 16'h0000, 16'd5,    32'h0,         0, 0, 17));
    tbl.push_back(mk(4'b0111, 16'hFFFF, 16'd16,   32'hFFFF_0000, 0, 0, 1));

    repeat (3) @(negedge clk);
    check("reset outputs", {bus.result, bus.zero, bus.busy, bus.done, bus.div_by_zero, bus.illegal_op}, 64'h0);
    rst = 1'b0;

    foreach (tbl[i])
      check_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
               tbl[i].res, tbl[i].z, tbl[i].dbz, tbl[i].ill, tbl[i].lat);

    for (int n = 0; n < 200; n++) begin
      op = 4'($urandom_range(0, 15));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(0, 40));
      if ($urandom_range(0, 7) == 0) rb = 16'h0;
      if ($urandom_range(0, 9) == 0) ra = 16'h0;
      m = model(op, ra, rb);
      check_op($sformatf("rand%0d", n), op, ra, rb, m.res, (m.res == 32'h0), m.dbz, m.ill, m.lat);
    end

    // MUL with start pulses (cycle 5 and the done cycle) that must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.alu_op = 4'b1001; bus.a = 16'hFFFF; bus.b = 16'hFFFF;
    @(posedge clk);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      check($sformatf("mul busy c%0d", cyc), 64'(bus.busy), 64'(cyc <= 17));
      check($sformatf("mul done c%0d", cyc), 64'(bus.done), 64'(cyc == 17));
      if (cyc == 17) check("mul hold result", 64'(bus.result), 64'h0000_0000_FFFE_0001);
      bus.start = (cyc == 5 || cyc == 17);
      bus.alu_op = 4'b0001; bus.a = 16'h0001; bus.b = 16'h0001;
    end
    bus.start = 1'b0;

    // Reset mid-MUL after a DIV-by-zero left result and flag set.
    check_op("pre-reset div0", 4'b1010, 16'd5, 16'd0, 32'h0000_FFFF, 1'b0, 1'b1, 1'b0, 17);
    @(negedge clk);
    bus.start = 1'b1; bus.alu_op = 4'b1001; bus.a = 16'd3; bus.b = 16'd4;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset mid-op outputs", {bus.result, bus.zero, bus.busy, bus.done, bus.div_by_zero, bus.illegal_op}, 64'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("in reset done c%0d", k), 64'(bus.done), 64'h0);
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check($sformatf("after reset idle c%0d", k), 64'({bus.done, bus.busy}), 64'h0);
    end
    check_op("post-reset sub", 4'b0010, 16'd3, 16'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the combinational 16-bit ALU.
- Same 4-bit opcode map, plus MOD.
- Operand width is set by WIDTH; the result is 2*WIDTH bits.
- MUL, DIV and MOD run as iterative multi-cycle ops, so no wide combinational multiplier or divider is needed. All other ops complete in one cycle.
- Sits between the register file and writeback. Control uses a start/busy/done handshake.

Parameters:
- WIDTH, 16: operand width in bits; minimum 4.
- CNT_W, $clog2(WIDTH+1): width of the iteration counter (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- alu_op  in  4  opcode.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse; result and flags are valid from this cycle.
- result  out  2*WIDTH  registered result; held until the next done.
- zero  out  1  (result==0), registered with result.
- div_by_zero  out  1  set with done when a DIV/MOD op had b==0.
- illegal_op  out  1  set with done when alu_op is not in the map.

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, operand and accumulator registers 0.
- Reset asserted mid-operation aborts the operation with no done pulse.
- FSM states and transitions:
  - IDLE: on start, latch a, b and alu_op. Single-cycle op -> DONE. MUL -> MUL. DIV/MOD -> DIV.
  - MUL: shift-add, one bit of b per cycle, LSB first, for WIDTH cycles, then -> DONE.
  - DIV: restoring division, one quotient bit per cycle, MSB first, for WIDTH cycles, then -> DONE.
  - DONE: write result, zero and flags; pulse done for 1 cycle; -> IDLE.
- Latency, counted from the start-accepted edge to done high:
  - Single-cycle ops: 1 cycle.
  - MUL, DIV, MOD: WIDTH+1 cycles.
- busy is high in MUL, DIV and DONE states, low in IDLE.
- Throughput: start is ignored while busy=1. A new start may be accepted in the cycle after done, once busy is low.
- Operands are latched at acceptance. Input changes during busy have no effect.
- Opcode map (operands zero-extended to 2*WIDTH):
  - 0001 ADD: a+b, carry lands in bit WIDTH.
  - 0010 SUB: a-b, computed modulo 2^(2*WIDTH).
  - 0011 AND, 0100 OR, 0101 XOR: bitwise.
  - 0110 NOT: ~a in the low WIDTH bits; upper bits 0.
  - 0111 SHL: a<<b. If b >= 2*WIDTH, result is 0.
  - 1000 SHR: a>>b. If b >= WIDTH, result is 0.
  - 1001 MUL: full 2*WIDTH-bit unsigned product.
  - 1010 DIV: unsigned quotient, zero-extended.
  - 1011 MOD: unsigned remainder, zero-extended.
- Divide by zero (b==0 on DIV/MOD): still takes full WIDTH+1 latency.
  - DIV result = {WIDTH'0, WIDTH'1s}.
  - MOD result = zero-extended a.
  - div_by_zero=1.
- Illegal opcode (0000, 1100-1111): 1-cycle latency, result=0, zero=1, illegal_op=1.
- div_by_zero and illegal_op update only at done. They are cleared by the next done that does not raise them.
- All arithmetic is unsigned. There is no overflow flag.

Decomposition:
- Shared package alu_pkg holds:
  - Opcode localparams: OP_ADD..OP_MOD.
  - FSM state encoding: IDLE, MUL, DIV, DONE.
- One sub-module is natural: alu_seq_divstep, a combinational single restoring-division step.
  - Inputs: partial remainder and divisor.
  - Outputs: next remainder and quotient bit.
  - Instantiated once and iterated by the FSM.

Test Plan:
- WIDTH=16, ADD a=16'hFFFF b=1 -> done 1 cycle after accept; result=32'h0001_0000, zero=0.
- MUL a=16'hFFFF b=16'hFFFF -> done at cycle 17; result=32'hFFFE_0001; busy high cycles 1-17. A start pulsed at cycle 5 is ignored.
- DIV a=100 b=7 -> result=14. MOD with the same operands -> result=2. DIV a=5 b=0 -> result=32'h0000_FFFF, div_by_zero=1, latency 17.
- SHL a=1 b=31 -> result=32'h8000_0000. SHR a=16'h8000 b=16 -> result=0, zero=1. NOT a=16'h00FF -> result=32'h0000_FF00.
- Opcode 4'b1111 -> done after 1 cycle; illegal_op=1, result=0, zero=1. A following ADD clears illegal_op.
- Start MUL, assert rst at cycle 6 -> all outputs 0 immediately and no done pulse. After release, SUB a=3 b=5 -> result=32'hFFFF_FFFE.
